// File: rtl/inst_fetcher.sv
// inst_fetcher: fetch stage that requests from the icache, predicts next PC and queues {pc, next_pc, inst} for the issuer.
// Define BRANCH_PREDICT_EN to predict JAL and backward branches; otherwise next PC is always pc+4.
module inst_fetcher #(
   parameter int          QUEUE_DEPTH = 4,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        is_any_full,
   output logic        ready_to_issuer,
   output logic [31:0] pc_to_issuer,
   output logic [31:0] next_pc_to_issuer,
   output logic [31:0] inst_to_issuer,
   output logic        valid_to_icache,
   output logic [31:0] addr_to_icache,
   input  logic        valid_from_icache,
   input  logic [31:0] inst_from_icache,
   input  logic        reset_from_rob_bus,
   input  logic [31:0] target_pc_from_rob_bus
);
   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(QUEUE_DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [AW:0]   count_q, count_d;
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [31:0]   pc_mem   [QUEUE_DEPTH];
   logic [31:0]   npc_mem  [QUEUE_DEPTH];
   logic [31:0]   inst_mem [QUEUE_DEPTH];
   logic          flush, pop, push, req;
   logic [31:0]   pred;

`ifdef BRANCH_PREDICT_EN
   logic [6:0]  op;
   logic [31:0] j_imm, b_imm;
   assign op    = inst_from_icache[6:0];
   assign j_imm = {{12{inst_from_icache[31]}}, inst_from_icache[19:12], inst_from_icache[20], inst_from_icache[30:21], 1'b0};
   assign b_imm = {{20{inst_from_icache[31]}}, inst_from_icache[7], inst_from_icache[30:25], inst_from_icache[11:8], 1'b0};
   // Backward branches are predicted taken, forward ones fall through.
   assign pred  = op == 7'h6f ? fetch_pc_q + j_imm :
                  (op == 7'h63 && inst_from_icache[31]) ? fetch_pc_q + b_imm : fetch_pc_q + 32'd4;
`else
   assign pred  = fetch_pc_q + 32'd4;
`endif

   always_comb begin
      flush    = rdy && reset_from_rob_bus;
      pop      = rdy && !flush && ready_to_issuer && !is_any_full;
      push     = rdy && !flush && state_q == WAIT && valid_from_icache;
      // Space is reserved at request time, so a later push always fits.
      req      = rdy && !flush && !rst && state_q == IDLE && count_q < FULL;
      head_d   = flush ? '0 : head_q + AW'(pop);
      tail_d   = flush ? '0 : tail_q + AW'(push);
      count_d  = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
      fetch_pc_d = flush ? target_pc_from_rob_bus : push ? pred : fetch_pc_q;
      state_d  = state_q;
      if (flush)
         state_d = (state_q != IDLE && !valid_from_icache) ? DROP : IDLE;
      else if (push || (rdy && state_q == DROP && valid_from_icache))
         state_d = IDLE;
      else if (req)
         state_d = WAIT;
   end

   assign ready_to_issuer   = count_q != '0;
   assign pc_to_issuer      = ready_to_issuer ? pc_mem[head_q]   : '0;
   assign next_pc_to_issuer = ready_to_issuer ? npc_mem[head_q]  : '0;
   assign inst_to_issuer    = ready_to_issuer ? inst_mem[head_q] : '0;
   assign valid_to_icache   = req;
   assign addr_to_icache    = req ? fetch_pc_q : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[tail_q]   <= fetch_pc_q;
         npc_mem[tail_q]  <= pred;
         inst_mem[tail_q] <= inst_from_icache;
      end
   end
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: directed and randomized checks of inst_fetcher against a transaction-level model of the fetch stream.
// Expectations follow BRANCH_PREDICT_EN when it is defined for the build.
module tb_inst_fetcher;
   localparam int          D   = 4;
   localparam logic [31:0] RPC = 32'h0;
`ifdef BRANCH_PREDICT_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   logic        clk = 0, rst = 0, rdy = 0, is_any_full = 0, valid_from_icache = 0, reset_from_rob_bus = 0;
   logic [31:0] inst_from_icache = 0, target_pc_from_rob_bus = 0;
   logic        ready_to_issuer, valid_to_icache;
   logic [31:0] pc_to_issuer, next_pc_to_issuer, inst_to_issuer, addr_to_icache;

   typedef struct {int kind; int off;} op_t;
   typedef struct {logic [31:0] pc; logic [31:0] npc; logic [31:0] inst;} ent_t;

   op_t         prog [logic [31:0]];
   logic [31:0] obs_npc [logic [31:0]];
   ent_t        q[$];
   logic [31:0] reqlog[$];
   bit          pend, dropped, rand_mode, req_last;
   logic [31:0] pend_addr, exp_req;
   int          wcnt, lat, n_chk, n_pass, n_fail, obs_pops;

   inst_fetcher #(.QUEUE_DEPTH(D), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .is_any_full(is_any_full),
      .ready_to_issuer(ready_to_issuer), .pc_to_issuer(pc_to_issuer),
      .next_pc_to_issuer(next_pc_to_issuer), .inst_to_issuer(inst_to_issuer),
      .valid_to_icache(valid_to_icache), .addr_to_icache(addr_to_icache),
      .valid_from_icache(valid_from_icache), .inst_from_icache(inst_from_icache),
      .reset_from_rob_bus(reset_from_rob_bus), .target_pc_from_rob_bus(target_pc_from_rob_bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // kind: 0 ADDI, 1 JAL, 2 BEQ, 3 JALR
   function automatic op_t getop(input logic [31:0] a);
      logic [31:0] h;
      op_t o;
      if (prog.exists(a)) return prog[a];
      o.kind = 0;
      o.off  = 4;
      if (!rand_mode) return o;
      h = a * 32'h9E3779B1;
      o.kind = int'(h[31:30]);
      o.off  = (int'(h[11:4]) - 128) * 4;
      return o;
   endfunction

   function automatic logic [31:0] enc(input op_t o);
      logic [31:0] v;
      v = 32'(o.off);
      case (o.kind)
         1:       return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'h6f};
         2:       return {v[12], v[10:5], 5'd2, 5'd1, 3'b000, v[4:1], v[11], 7'h63};
         3:       return {12'd0, 5'd1, 3'b000, 5'd0, 7'h67};
         default: return {12'd5, 5'd1, 3'b000, 5'd1, 7'h13};
      endcase
   endfunction

   function automatic logic [31:0] pred(input logic [31:0] pc, input op_t o);
      if (BP && (o.kind == 1 || (o.kind == 2 && o.off < 0))) return pc + 32'(o.off);
      return pc + 32'd4;
   endfunction

   function automatic logic [31:0] req_at(input int i);
      return (i >= 0 && i < reqlog.size()) ? reqlog[i] : 32'hdeadbeef;
   endfunction

   function automatic logic [31:0] npc_of(input logic [31:0] a);
      return obs_npc.exists(a) ? obs_npc[a] : 32'hdeadbeef;
   endfunction

   task automatic model_reset();
      q.delete();
      pend = 0;
      dropped = 0;
      exp_req = RPC;
      valid_from_icache = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ready"}, 32'(ready_to_issuer), 32'h0);
      chk({tag, "_pc"}, pc_to_issuer, 32'h0);
      chk({tag, "_npc"}, next_pc_to_issuer, 32'h0);
      chk({tag, "_inst"}, inst_to_issuer, 32'h0);
      chk({tag, "_req"}, 32'(valid_to_icache), 32'h0);
      chk({tag, "_addr"}, addr_to_icache, 32'h0);
   endtask

   // One clock cycle: drive, check against the model, then advance the model across the edge.
   task automatic step(input bit r, input bit f, input bit fl, input logic [31:0] tgt);
      op_t o;
      ent_t e;
      bit exp_v;
      rdy = r;
      is_any_full = f;
      reset_from_rob_bus = fl;
      target_pc_from_rob_bus = tgt;
      valid_from_icache = pend && wcnt == 0;
      inst_from_icache = enc(getop(pend_addr));
      #1;
      chk("ready", 32'(ready_to_issuer), 32'(q.size() != 0));
      if (q.size() != 0) e = q[0];
      else begin
         e.pc = 0;
         e.npc = 0;
         e.inst = 0;
      end
      chk("head_pc", pc_to_issuer, e.pc);
      chk("head_npc", next_pc_to_issuer, e.npc);
      chk("head_inst", inst_to_issuer, e.inst);
      if (ready_to_issuer) obs_npc[pc_to_issuer] = next_pc_to_issuer;
      exp_v = r && !fl && !pend && q.size() < D;
      chk("req", 32'(valid_to_icache), 32'(exp_v));
      chk("addr", addr_to_icache, exp_v ? exp_req : 32'h0);
      req_last = valid_to_icache;
      if (r && !fl && ready_to_issuer && !f) obs_pops++;
      if (r) begin
         if (fl) begin
            q.delete();
            exp_req = tgt;
            if (pend && valid_from_icache) begin
               pend = 0;
               dropped = 0;
            end else if (pend) dropped = 1;
         end else begin
            if (q.size() != 0 && !f) void'(q.pop_front());
            if (valid_from_icache) begin
               if (!dropped) begin
                  o = getop(pend_addr);
                  e.pc = pend_addr;
                  e.inst = enc(o);
                  e.npc = pred(pend_addr, o);
                  q.push_back(e);
                  exp_req = e.npc;
               end
               pend = 0;
               dropped = 0;
            end
         end
      end
      if (pend && wcnt > 0) wcnt--;
      if (valid_to_icache) begin
         pend = 1;
         pend_addr = addr_to_icache;
         wcnt = (lat == 0 ? $urandom_range(1, 3) : lat) - 1;
         reqlog.push_back(addr_to_icache);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input int n, input bit f);
      for (int i = 0; i < n; i++) step(1'b1, f, 1'b0, 32'h0);
   endtask

   task automatic wait_req(input bit f);
      for (int i = 0; i < 20 && !req_last; i++) step(1'b1, f, 1'b0, 32'h0);
      chk("wait_req", 32'(req_last), 32'h1);
   endtask

   initial begin
      int idx, n0, p0;
      lat = 2;
      prog[32'h10] = '{kind: 1, off: 32'h20};
      prog[32'h40] = '{kind: 2, off: -8};
      prog[32'h80] = '{kind: 2, off: 8};
      rdy = 1;
      #1 rst = 1;
      #1 chk_zero("rst");
      model_reset();
      @(negedge clk);
      rst = 0;

      run(24, 1'b0);
      chk("req0", req_at(0), 32'h0);
      chk("req1", req_at(1), 32'h4);
      chk("req2", req_at(2), 32'h8);
      chk("npc0", npc_of(32'h0), 32'h4);
      chk("npc4", npc_of(32'h4), 32'h8);
      chk("npc8", npc_of(32'h8), 32'hc);
      chk("jal_npc", npc_of(32'h10), BP ? 32'h30 : 32'h14);
      idx = -1;
      foreach (reqlog[i]) if (reqlog[i] == 32'h10 && idx < 0) idx = i;
      chk("jal_next_req", req_at(idx < 0 ? -1 : idx + 1), BP ? 32'h30 : 32'h14);

      step(1'b1, 1'b0, 1'b1, 32'h40);
      run(10, 1'b0);
      chk("beq_back", npc_of(32'h40), BP ? 32'h38 : 32'h44);
      step(1'b1, 1'b0, 1'b1, 32'h80);
      run(10, 1'b0);
      chk("beq_fwd", npc_of(32'h80), 32'h84);
      step(1'b1, 1'b0, 1'b1, 32'hfffffffc);
      run(6, 1'b0);
      chk("pc_wrap", npc_of(32'hfffffffc), 32'h0);

      lat = 1;
      step(1'b1, 1'b0, 1'b1, 32'h200);
      n0 = reqlog.size();
      run(30, 1'b1);
      chk("full_reqs", 32'(reqlog.size() - n0), 32'd4);
      chk("full_ready", 32'(ready_to_issuer), 32'h1);
      p0 = obs_pops;
      run(4, 1'b0);
      chk("drain_pops", 32'(obs_pops - p0), 32'd4);

      lat = 2;
      step(1'b1, 1'b0, 1'b1, 32'h300);
      wait_req(1'b0);
      step(1'b1, 1'b0, 1'b1, 32'h100);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("drop_empty", 32'(ready_to_issuer), 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("flush_req_seen", 32'(req_last), 32'h1);
      chk("flush_req_addr", req_at(reqlog.size() - 1), 32'h100);

      lat = 3;
      step(1'b1, 1'b0, 1'b1, 32'h400);
      run(6, 1'b1);
      req_last = 0;
      wait_req(1'b1);
      chk("pre_rst_ready", 32'(ready_to_issuer), 32'h1);
      rdy = 1;
      is_any_full = 0;
      valid_from_icache = 0;
      #3 rst = 1;
      #1 chk_zero("rst_mid");
      model_reset();
      @(negedge clk);
      rst = 0;
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("rst_req_seen", 32'(req_last), 32'h1);
      chk("rst_req_addr", req_at(reqlog.size() - 1), RPC);

      lat = 0;
      rand_mode = 1;
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0, $urandom & 32'hfffffffc);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
